// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register command sequencer: op encodings,
// FSM state type and the default register width.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : shift_pkg

// File: rtl/shift_seq.sv
// Command sequencer driving a 4-bit universal shift register (one-hot sr/sl/ld).
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_in,
    output logic             sr,
    output logic             sl,
    output logic             ld,
    output logic [WIDTH-1:0] d_out,
    output logic             d_sr,
    output logic             d_sl,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fill_q;
    logic             take;

    // The source holds its command until ready, so accepting in IDLE is enough.
    assign take = (state == ST_IDLE) && cmd_valid;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_LOAD;
            data_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                cnt_q  <= cmd_cnt;
                fill_q <= cmd_fill;
            end else if (state == ST_SHIFT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        state_next = ST_LOAD;
                    end else if (cmd_cnt == '0) begin
                        state_next = ST_DONE;
`ifndef SHIFT_SEQ_ROTATE_EN
                    end else if (cmd_op == OP_ROR) begin
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_LOAD:  state_next = ST_DONE;
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low during reset so the register clears on that edge.
    always_comb begin
        sr        = 1'b0;
        sl        = 1'b0;
        ld        = 1'b0;
        d_out     = '0;
        d_sr      = 1'b0;
        d_sl      = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    ld        = 1'b1;
                    d_out     = q_in;
                    cmd_ready = 1'b1;
                end
                ST_LOAD: begin
                    ld    = 1'b1;
                    d_out = data_q;
                    busy  = 1'b1;
                end
                ST_SHIFT: begin
                    busy = 1'b1;
                    case (op_q)
                        OP_SHR: begin
                            sr   = 1'b1;
                            d_sr = fill_q;
                        end
                        OP_SHL: begin
                            sl   = 1'b1;
                            d_sl = fill_q;
                        end
`ifdef SHIFT_SEQ_ROTATE_EN
                        OP_ROR: begin
                            sr   = 1'b1;
                            d_sr = q_in[0];
                        end
`endif
                        default: begin
                            // Unreachable; hold rather than let the register clear.
                            ld    = 1'b1;
                            d_out = q_in;
                        end
                    endcase
                end
                ST_DONE: begin
                    ld    = 1'b1;
                    d_out = q_in;
                    busy  = 1'b1;
                    done  = 1'b1;
                end
                default: begin
                    ld    = 1'b1;
                    d_out = q_in;
                end
            endcase
        end
    end

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq paired with a behavioural universal shift
// register; SHIFT_SEQ_ROTATE_EN selects the rotate expectations.
module tb_shift_seq;
    import shift_pkg::*;

    localparam int W  = 4;
    localparam int CW = 3;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          cmd_fill = 1'b0;
    logic [W-1:0]  q = 4'hF;
    logic          sr, sl, ld, d_sr, d_sl, busy, done;
    logic [W-1:0]  d_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .q_in(q), .sr(sr), .sl(sl), .ld(ld), .d_out(d_out),
        .d_sr(d_sr), .d_sl(d_sl), .busy(busy), .done(done)
    );

    // Downstream universal shift register: loads 0 when no control is high.
    always @(posedge clk) begin
        if (ld)      q <= d_out;
        else if (sr) q <= {d_sr, q[3:1]};
        else if (sl) q <= {q[2:0], d_sl};
        else         q <= '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // ---------------- behavioural model: per-cycle expectation plan ----------------
    typedef struct {
        logic         busy;
        logic         done;
        logic [W-1:0] q;
    } exp_t;

    exp_t cur;
    exp_t plan[$];
    bit   model_valid = 1'b0;
    bit   accepted    = 1'b0;
    int   cyc         = 0;
    int   accept_log[$];

    function automatic logic [W-1:0] step(input logic [1:0] op, input logic [W-1:0] v,
                                          input logic fill);
        int x;
        x = int'(v);
        case (op)
            OP_SHR:  x = (x >> 1) + (fill ? 8 : 0);
            OP_SHL:  x = ((x * 2) + (fill ? 1 : 0)) % 16;
            default: x = (x >> 1) + ((x % 2) * 8);
        endcase
        return W'(x);
    endfunction

    always @(posedge clk) begin
        cyc++;
        accepted = 1'b0;
        if (rst) begin
            plan.delete();
            cur = '{busy: 1'b0, done: 1'b0, q: '0};
            model_valid = 1'b1;
        end else if (plan.size() > 0) begin
            cur = plan.pop_front();
        end else if (model_valid && !cur.busy && cmd_valid) begin
            logic [W-1:0] v;
            accepted = 1'b1;
            accept_log.push_back(cyc);
            v = cur.q;
            if (cmd_op == OP_LOAD) begin
                plan.push_back('{busy: 1'b1, done: 1'b0, q: v});
                plan.push_back('{busy: 1'b1, done: 1'b1, q: cmd_data});
            end else if (cmd_cnt == 0 || (cmd_op == OP_ROR && !ROT)) begin
                plan.push_back('{busy: 1'b1, done: 1'b1, q: v});
            end else begin
                for (int i = 0; i < int'(cmd_cnt); i++) begin
                    plan.push_back('{busy: 1'b1, done: 1'b0, q: v});
                    v = step(cmd_op, v, cmd_fill);
                end
                plan.push_back('{busy: 1'b1, done: 1'b1, q: v});
            end
            cur = plan.pop_front();
        end else begin
            cur = '{busy: 1'b0, done: 1'b0, q: cur.q};
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("q", q, cur.q);
            if (rst) begin
                check("ctl_in_reset", {sr, sl, ld, d_sr, d_sl, busy, done, cmd_ready}, 0);
                check("d_out_in_reset", d_out, 0);
            end else begin
                check("busy", busy, cur.busy);
                check("done", done, cur.done);
                check("cmd_ready", cmd_ready, !cur.busy);
                check("one_hot", int'(sr) + int'(sl) + int'(ld), 1);
                if (!sr) check("d_sr_unused", d_sr, 0);
                if (!sl) check("d_sl_unused", d_sl, 0);
                if (!cur.busy || cur.done) check("hold_d_out", d_out, q);
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [W-1:0] traj[$];
    int           sr_cnt = 0;

    always @(negedge clk) begin
        if (!rst && busy) traj.push_back(q);
        if (sr) sr_cnt++;
    end

    // Called at #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [CW-1:0] cnt, input logic fill);
        bit got;
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = fill; cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            if (accepted) got = 1'b1;
        end
        if (!got) timeout_fail("accept");
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                           input logic [CW-1:0] cnt, input logic fill);
        bit got;
        traj.delete();
        sr_cnt = 0;
        issue(op, data, cnt, fill);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) timeout_fail("done");
        @(posedge clk); #1;
    endtask

    task automatic check_traj(input string name, input logic [W-1:0] e[$]);
        check({name, "_len"}, traj.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < traj.size()) check(name, traj[i], e[i]);
    endtask

    initial begin
        logic [W-1:0] e[$];

        // Reset with register preloaded to F.
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", q, 4'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_reset_q", q, 4'h0);
        check("post_reset_ready", cmd_ready, 1);
        @(posedge clk); #1;

        run_cmd(OP_LOAD, 4'hA, 3'd0, 1'b0);
        check("load_q", q, 4'hA);
        e = '{4'h0, 4'hA};
        check_traj("load_traj", e);
        repeat (10) @(posedge clk);
        #1;
        check("load_hold_q", q, 4'hA);

        run_cmd(OP_SHR, 4'h0, 3'd2, 1'b1);
        e = '{4'hA, 4'hD, 4'hE};
        check_traj("shr_traj", e);
        check("shr_sr_cycles", sr_cnt, 2);
        check("shr_busy_after", busy, 0);

        run_cmd(OP_LOAD, 4'h3, 3'd0, 1'b0);
        run_cmd(OP_SHL, 4'h0, 3'd3, 1'b0);
        e = '{4'h3, 4'h6, 4'hC, 4'h8};
        check_traj("shl_traj", e);

        run_cmd(OP_SHL, 4'h0, 3'd0, 1'b1);
        e = '{4'h8};
        check_traj("cnt0_traj", e);
        check("cnt0_q", q, 4'h8);

        run_cmd(OP_LOAD, 4'h1, 3'd0, 1'b0);
        run_cmd(OP_ROR, 4'h0, 3'd5, 1'b0);
        if (ROT) e = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8};
        else     e = '{4'h1};
        check_traj("ror_traj", e);

        // Back-pressure: second command waits with valid held until IDLE.
        accept_log.delete();
        issue(OP_LOAD, 4'h5, 3'd0, 1'b0);
        traj.delete();
        issue(OP_SHR, 4'h0, 3'd1, 1'b0);
        if (accept_log.size() == 2)
            check("backpressure_gap", accept_log[1] - accept_log[0], 3);
        else
            check("backpressure_accepts", accept_log.size(), 2);
        repeat (2) @(posedge clk);
        #1;
        check("backpressure_q", q, 4'h2);

        // Abort a shift with reset.
        issue(OP_SHL, 4'h0, 3'd7, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_q", q, 4'h0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // Randomized traffic with held-valid back-pressure and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if (!cmd_valid || accepted) begin
                if ($urandom_range(3) == 0) begin
                    cmd_valid = 1'b0;
                end else begin
                    cmd_valid = 1'b1;
                    cmd_op    = 2'($urandom_range(3));
                    cmd_data  = W'($urandom);
                    cmd_cnt   = CW'($urandom);
                    cmd_fill  = 1'($urandom);
                end
            end
            rst = ($urandom_range(79) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_seq

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Command sequencer directly upstream of the 4-bit universal shift register.
- Accepts LOAD / shift-right / shift-left / rotate commands over a valid/ready handshake.
- Drives the register's one-hot controls (sr, sl, ld) and its data and serial inputs for the required number of cycles.
- Reads back the register's Q so that it can hold Q while idle and rotate it.

Parameters:
- WIDTH, 4, register width; must match the downstream shift register.
- CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock, shared with the shift register
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer accepts a command this cycle
- cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROR
- cmd_data  input  WIDTH  parallel value for LOAD
- cmd_cnt  input  CNT_W  number of shift cycles (SHR/SHL/ROR)
- cmd_fill  input  1  serial fill bit for SHR/SHL
- q_in  input  WIDTH  Q fed back from the shift register
- sr  output  1  shift-right enable to the register
- sl  output  1  shift-left enable to the register
- ld  output  1  parallel-load enable to the register
- d_out  output  WIDTH  parallel data to the register's D
- d_sr  output  1  serial input for right shift, enters the MSB
- d_sl  output  1  serial input for left shift, enters the LSB
- busy  output  1  a command is executing
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Downstream register loads 0 whenever sr=sl=ld=0, so the sequencer never leaves all three low outside reset.
- At most one of sr, sl, ld is high in any cycle.
- Control outputs are combinational from state registers; the state registers only change on the rising edge of clk.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- Reset (rst=1 at an edge):
  - state becomes IDLE; cnt, op, fill, data registers become 0.
  - While rst is high: sr=sl=ld=0, d_out=0, d_sr=d_sl=0, cmd_ready=0, busy=0, done=0.
  - Consequence: the downstream Q clears to 0 at the same edge.
- Reset mid-command aborts the command; no done pulse is produced.
- IDLE:
  - Hold: ld=1, d_out=q_in; cmd_ready=1, busy=0.
  - A transfer occurs when cmd_valid and cmd_ready are both high. On the transfer, op, data, cnt and fill are captured.
  - Next state: LOAD if op=00; DONE if cnt=0; otherwise SHIFT.
- LOAD: for exactly one cycle, ld=1, d_out=captured data; then DONE.
- SHIFT:
  - SHR: sr=1, d_sr=fill.
  - SHL: sl=1, d_sl=fill.
  - ROR: sr=1, d_sr=q_in[0].
  - Remaining count decrements each cycle; when it reaches 1, the next state is DONE.
  - Exactly cnt shift cycles occur.
- DONE: hold (ld=1, d_out=q_in), done=1, busy=1, cmd_ready=0; next state IDLE.
- busy=1 in LOAD, SHIFT and DONE; cmd_ready=0 in those states.
- cmd_valid high outside IDLE is ignored; the command is not lost, since the source holds it until it sees ready.
- Latency: accept edge -> first action cycle -> done one cycle after the last action.
  - LOAD: 3 cycles accept-to-IDLE.
  - Shift: cnt+2 cycles accept-to-IDLE.
  - cnt=0: done in the cycle after accept; the register value is unchanged.
- Unused serial outputs are 0.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- Defined: op 11 performs ROR as described above.
- Undefined:
  - op 11 is accepted and treated as a no-op: goes straight to DONE and holds Q.
  - The ROR datapath (q_in[0] -> d_sr mux) is not synthesised.

Decomposition:
- Shared package shift_pkg contains:
  - op encodings OP_LOAD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_ROR=2'b11;
  - FSM state enum;
  - default WIDTH.
- No sub-module; the down-counter is inline.
- The bench instantiates shift_seq together with the existing shift register.

Test Plan:
- Reset: rst=1 for 2 cycles with register Q=4'hF -> Q=0, cmd_ready=0, done=0; after release, cmd_ready=1 and Q holds 0 indefinitely.
- LOAD: cmd op=00, data=4'hA -> ld pulse with d_out=A, Q=4'hA, done one cycle later, then Q stays 4'hA for 10 idle cycles.
- SHR: Q=4'hA, op=01, cnt=2, fill=1 -> Q sequence A,D,E; exactly 2 sr cycles; done; busy low after.
- SHL and cnt=0: Q=4'h3, op=10, cnt=3, fill=0 -> Q=6,C,8. Then op=10, cnt=0 -> done next cycle, Q stays 8.
- ROR with macro defined: Q=4'h1, op=11, cnt=5 -> Q=8,4,2,1,8. Macro undefined: same command -> no-op, Q stays 1, done pulses.
- Back-pressure and abort:
  - cmd_valid held high throughout a command -> second command accepted only in IDLE.
  - rst asserted during SHIFT -> no done pulse, Q=0, FSM in IDLE.
